// File: rtl/aes_key_expand.sv
`default_nettype none
// ============================================================================
// Module   : aes_key_expand (with helper aes_key_expand_sbox)
// Purpose  : Iterative AES-128 key schedule. Produces round keys 0..10, one
//            per valid/ready handshake. The next key is computed
//            combinationally from the current rk_out register. SubWord uses
//            four S-box instances, one per byte.
// Ports    : clk, rst           - clock, synchronous active-high reset
//            start, key_in      - begin expansion of key_in (IDLE only)
//            rk_out, rk_round   - current round key and its index 0..10
//            rk_valid, rk_ready - output handshake
//            busy               - high while expanding
//            done               - one-cycle pulse after key 10 is accepted
//            rd_addr, rd_key    - key store read port (AES_KEY_STORE_EN only)
// Options  : AES_KEY_STORE_EN - adds an 11x128 round-key store. The store is
//            cleared on rst and keeps its contents while IDLE.
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// AES forward S-box, one byte in, one byte out, pure lookup.
// ----------------------------------------------------------------------------
module aes_key_expand_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);
  // Entry 0 is the most significant byte, so C_SBOX[x] is S(x).
  localparam logic [0:255][7:0] C_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign out_byte = C_SBOX[in_byte];
endmodule

// ----------------------------------------------------------------------------
// Key schedule top level.
// ----------------------------------------------------------------------------
module aes_key_expand #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_round,
  output logic         rk_valid,
  input  logic         rk_ready,
`ifdef AES_KEY_STORE_EN
  input  logic [3:0]   rd_addr,
  output logic [127:0] rd_key,
`endif
  output logic         busy,
  output logic         done
);

  // Only the AES-128 schedule is implemented; refuse to elaborate otherwise.
  generate
    if (NR != 10) begin : g_bad_nr
      $error("aes_key_expand: NR must be 10 (AES-128)");
    end
  endgenerate

  localparam logic [3:0] C_LAST_ROUND = 4'(NR);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t         state_q,    state_d;
  logic [127:0]   rk_out_q,   rk_out_d;
  logic [3:0]     rk_round_q, rk_round_d;
  logic           rk_valid_q, rk_valid_d;
  logic           busy_q,     busy_d;
  logic           done_q,     done_d;

  // Round constant for the key being produced (r = 1..10).
  function automatic logic [7:0] rcon_f(input logic [3:0] r);
    logic [7:0] rc;
    rc = 8'h00;
    case (r)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  // --------------------------------------------------------------------------
  // Next-key datapath: straight from the rk_out register.
  // --------------------------------------------------------------------------
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot_w3, sub_w3, t_word;
  logic [31:0]  nw0, nw1, nw2, nw3;
  logic [127:0] next_key;
  logic [3:0]   next_round;

  assign w0 = rk_out_q[127:96];
  assign w1 = rk_out_q[95:64];
  assign w2 = rk_out_q[63:32];
  assign w3 = rk_out_q[31:0];

  // RotWord({b0,b1,b2,b3}) = {b1,b2,b3,b0}
  assign rot_w3 = {w3[23:0], w3[31:24]};

  generate
    for (genvar i = 0; i < 4; i++) begin : g_sbox
      aes_key_expand_sbox u_sbox (
        .in_byte  (rot_w3[8*i +: 8]),
        .out_byte (sub_w3[8*i +: 8])
      );
    end
  endgenerate

  assign next_round = rk_round_q + 4'd1;
  assign t_word     = sub_w3 ^ {rcon_f(next_round), 24'h000000};
  assign nw0        = w0 ^ t_word;
  assign nw1        = w1 ^ nw0;
  assign nw2        = w2 ^ nw1;
  assign nw3        = w3 ^ nw2;
  assign next_key   = {nw0, nw1, nw2, nw3};

  // --------------------------------------------------------------------------
  // Control
  // --------------------------------------------------------------------------
  logic handshake;
  assign handshake = rk_valid_q && rk_ready;

  always_comb begin
    state_d    = state_q;
    rk_out_d   = rk_out_q;
    rk_round_d = rk_round_q;
    rk_valid_d = rk_valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_RUN;
          rk_out_d   = key_in;
          rk_round_d = 4'd0;
          rk_valid_d = 1'b1;
          busy_d     = 1'b1;
        end
      end
      ST_RUN: begin
        if (handshake) begin
          if (rk_round_q == C_LAST_ROUND) begin
            // Last key taken: leave rk_out/rk_round holding round 10.
            state_d    = ST_IDLE;
            rk_valid_d = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
          end else begin
            rk_out_d   = next_key;
            rk_round_d = next_round;
          end
        end
      end
      default: begin
        state_d    = ST_IDLE;
        rk_valid_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rk_out_q   <= '0;
      rk_round_q <= '0;
      rk_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rk_out_q   <= rk_out_d;
      rk_round_q <= rk_round_d;
      rk_valid_q <= rk_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign rk_out   = rk_out_q;
  assign rk_round = rk_round_q;
  assign rk_valid = rk_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

`ifdef AES_KEY_STORE_EN
  // --------------------------------------------------------------------------
  // Round-key store: each key is written as it is loaded into rk_out, so the
  // entry is readable in the same cycle the key becomes valid.
  // --------------------------------------------------------------------------
  logic [127:0] store_q [0:10];
  logic         load_en;

  assign load_en = ((state_q == ST_IDLE) && start) ||
                   ((state_q == ST_RUN) && handshake && (rk_round_q != C_LAST_ROUND));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 11; i++) begin
        store_q[i] <= '0;
      end
    end else if (load_en) begin
      store_q[rk_round_d] <= rk_out_d;
    end
  end

  assign rd_key = (rd_addr <= 4'd10) ? store_q[rd_addr] : '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_aes_key_expand.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_key_expand
// Purpose  : Self-checking bench for aes_key_expand. The expected round keys
//            come from a word-list key expansion model whose S-box is derived
//            from GF(2^8) inversion plus the affine transform.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_key_expand;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;
  logic         rk_valid;
  logic         rk_ready;
  logic         busy;
  logic         done;
`ifdef AES_KEY_STORE_EN
  logic [3:0]   rd_addr;
  logic [127:0] rd_key;
`endif

  aes_key_expand #(.NR(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key_in   (key_in),
    .rk_out   (rk_out),
    .rk_round (rk_round),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
`ifdef AES_KEY_STORE_EN
    .rd_addr  (rd_addr),
    .rd_key   (rd_key),
`endif
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] C_FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic [7:0]   sb    [0:255];
  logic [127:0] m_rk  [0:10];
  logic [127:0] obs_rk[0:10];

  // ---------------- reference model ----------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl1(input logic [7:0] v);
    return {v[6:0], v[7]};
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s, r;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      s = inv;
      r = inv;
      for (int k = 0; k < 4; k++) begin
        r = rotl1(r);
        s = s ^ r;
      end
      sb[x] = s ^ 8'h63;
    end
  endtask

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h000000};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) m_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Start an expansion of key (start driven now, sampled at next edge) with
  // rk_ready held high; check every key, timing and the done pulse.
  task automatic run_full(input string name, input logic [127:0] key);
    expand(key);
    rk_ready = 1'b1;
    key_in   = key;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    chk($sformatf("%s_done_low_after_start", name), 128'(done), 128'd0);
    for (int k = 0; k < 11; k++) begin
      chk($sformatf("%s_valid_r%0d", name, k), 128'(rk_valid), 128'd1);
      chk($sformatf("%s_busy_r%0d", name, k), 128'(busy), 128'd1);
      chk($sformatf("%s_round_r%0d", name, k), 128'(rk_round), 128'(k));
      chk($sformatf("%s_key_r%0d", name, k), rk_out, m_rk[k]);
      obs_rk[k] = rk_out;
      if (k < 10) tick();
    end
    chk($sformatf("%s_no_early_done", name), 128'(done), 128'd0);
    tick();
    chk($sformatf("%s_done_pulse", name), 128'(done), 128'd1);
    chk($sformatf("%s_valid_off", name), 128'(rk_valid), 128'd0);
    chk($sformatf("%s_busy_off", name), 128'(busy), 128'd0);
    chk($sformatf("%s_hold_key", name), rk_out, m_rk[10]);
    chk($sformatf("%s_hold_round", name), 128'(rk_round), 128'd10);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [127:0] prev_out;
    logic [3:0]   prev_round;
    logic         have_prev, rdy;
    int           exp_idx, dones, post, guard;

    rst = 1'b1; start = 1'b0; key_in = '0; rk_ready = 1'b0;
`ifdef AES_KEY_STORE_EN
    rd_addr = 4'd0;
`endif
    build_sbox();
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("reset_rk_out", rk_out, 128'd0);
    chk("reset_rk_round", 128'(rk_round), 128'd0);
    chk("reset_valid", 128'(rk_valid), 128'd0);
    chk("reset_busy", 128'(busy), 128'd0);
    chk("reset_done", 128'(done), 128'd0);

    // FIPS-197 vector, continuous ready: done 12 edges after start is driven
    run_full("fips", C_FIPS_KEY);
    chk("fips_r0_const", obs_rk[0], C_FIPS_KEY);
    chk("fips_r1_const", obs_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("fips_r2_const", obs_rk[2], 128'hf2c295f27a96b9435935807a7359f67f);
    chk("fips_r10_const", obs_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    tick();
    chk("fips_done_one_cycle", 128'(done), 128'd0);

`ifdef AES_KEY_STORE_EN
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      #1;
      chk($sformatf("store_fips_addr%0d", a), rd_key, (a <= 10) ? m_rk[a] : 128'd0);
    end
    rd_addr = 4'd0;  #1; chk("store_addr0_key", rd_key, C_FIPS_KEY);
    rd_addr = 4'd10; #1; chk("store_addr10", rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    rd_addr = 4'd15; #1; chk("store_addr15", rd_key, 128'd0);
`endif

    // Backpressure with random ready
    expand(C_FIPS_KEY);
    key_in = C_FIPS_KEY; start = 1'b1; rk_ready = 1'b0;
    tick();
    start = 1'b0;
    exp_idx = 0; dones = 0; post = 0; have_prev = 1'b0;
    prev_out = '0; prev_round = '0;
    for (int cyc = 0; cyc < 400 && !(exp_idx == 11 && post >= 3); cyc++) begin
      if (rk_valid) begin
        chk("bp_round", 128'(rk_round), 128'(exp_idx));
        chk("bp_key", rk_out, m_rk[exp_idx]);
      end
      if (have_prev) begin
        chk("bp_stable_key", rk_out, prev_out);
        chk("bp_stable_round", 128'(rk_round), 128'(prev_round));
      end
      if (done) dones++;
      if (exp_idx == 11) post++;
      rdy        = 1'($urandom_range(0, 1));
      have_prev  = rk_valid && !rdy;
      prev_out   = rk_out;
      prev_round = rk_round;
      if (rk_valid && rdy) exp_idx++;
      rk_ready = rdy;
      tick();
    end
    chk("bp_all_keys_taken", 128'(exp_idx), 128'd11);
    chk("bp_done_once", 128'(dones), 128'd1);

    // start with a different key while busy must be ignored
    rk_ready = 1'b1; key_in = C_FIPS_KEY; start = 1'b1;
    tick();
    for (int k = 0; k < 11; k++) begin
      chk($sformatf("ign_round_r%0d", k), 128'(rk_round), 128'(k));
      chk($sformatf("ign_key_r%0d", k), rk_out, m_rk[k]);
      if (k < 10) begin
        start  = 1'b1;
        key_in = rand_key();
        tick();
      end
    end
    start = 1'b0;
    tick();
    chk("ign_done", 128'(done), 128'd1);
    tick();
    chk("ign_no_restart", 128'(rk_valid), 128'd0);

    // Reset at round 5 aborts without done
    expand(rand_key());
    key_in = m_rk[0]; start = 1'b1; rk_ready = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while (rk_round != 4'd5 && guard < 20) begin
      tick();
      guard++;
    end
    chk("rst5_reached_round5", 128'(rk_round), 128'd5);
    chk("rst5_key5", rk_out, m_rk[5]);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst5_rk_out", rk_out, 128'd0);
    chk("rst5_round", 128'(rk_round), 128'd0);
    chk("rst5_valid", 128'(rk_valid), 128'd0);
    chk("rst5_busy", 128'(busy), 128'd0);
    chk("rst5_done", 128'(done), 128'd0);
    tick();
    chk("rst5_no_done_later", 128'(done), 128'd0);
    chk("rst5_idle", 128'(busy), 128'd0);

`ifdef AES_KEY_STORE_EN
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      #1;
      chk($sformatf("store_cleared_addr%0d", a), rd_key, 128'd0);
    end
`endif

    run_full("after_rst", rand_key());

    // All-zero key; the next run starts in the done-pulse cycle
    run_full("zero", 128'd0);
    chk("zero_r1_const", obs_rk[1], 128'h62636363626363636263636362636363);
    chk("zero_r10_const", obs_rk[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    // Random keys, back-to-back (start during each done pulse)
    for (int n = 0; n < 3; n++) begin
      run_full($sformatf("rand%0d", n), rand_key());
    end
    tick();
    chk("final_done_low", 128'(done), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aes_key_expand.md
Name: aes_key_expand

Overview:
- Iterative AES-128 key schedule. It consumes S-box lookups for SubWord and produces round keys 0..10, one per accepted handshake.
- Sits downstream of four Sbox instances, which it instantiates for SubWord, and upstream of the AddRoundKey logic in the cipher datapath.
- Uses a valid/ready output handshake so the cipher round controller can stall key delivery.

Parameters:
- NR, 10, number of rounds. Fixed at 10 for AES-128; any other value is unsupported and must be rejected by a generate-time error.

Ports:
- clk  input  1  Single clock. All state changes on the rising edge.
- rst  input  1  Reset, synchronous, active-high.
- start  input  1  Begin expansion of key_in. Sampled only in IDLE.
- key_in  input  128  Cipher key. w0 = key_in[127:96], w3 = key_in[31:0].
- rk_out  output  128  Current round key, same word ordering as key_in.
- rk_round  output  4  Index of rk_out, 0..10.
- rk_valid  output  1  rk_out/rk_round are valid.
- rk_ready  input  1  Consumer accepts the key when rk_valid && rk_ready.
- busy  output  1  High in RUN.
- done  output  1  One-cycle pulse after round key 10 is accepted.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state=IDLE; rk_out=0, rk_round=0, rk_valid=0, busy=0, done=0.
  - Reset mid-expansion aborts immediately; no done pulse.
- States: IDLE, RUN.
- IDLE:
  - done=0 except during the single pulse cycle.
  - start=1 → next cycle: rk_out=key_in, rk_round=0, rk_valid=1, busy=1, state=RUN.
  - Latency from start to first valid key is 1 cycle.
- RUN, rk_valid=1, rk_ready=0:
  - Hold rk_out and rk_round stable. No other state changes.
- RUN, handshake with rk_round<10:
  - Next cycle: rk_out = next key, rk_round+1, rk_valid stays 1.
  - Throughput is one key per cycle under continuous ready.
- RUN, handshake with rk_round=10:
  - Next cycle: state=IDLE, rk_valid=0, busy=0, done=1 for exactly one cycle.
  - rk_out holds the round-10 key; rk_round holds 10.
- start while busy: ignored, no restart.
- start in the same cycle as the done pulse: accepted, because state is already IDLE.
- Next-key arithmetic, all XORs 32-bit, no carries:
  - t = SubWord(RotWord(w3)) ^ {rcon[r], 24'h0}, where r = index of the new key (1..10).
  - RotWord({b0,b1,b2,b3}) = {b1,b2,b3,b0}.
  - SubWord uses four S-box instances, one per byte.
  - rcon = 01,02,04,08,10,20,40,80,1b,36 for r=1..10.
  - w0'=w0^t; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
- The next-key path is combinational from the rk_out register into the rk_out register; no multicycle paths.
- rk_round never exceeds 10 and never wraps.

Optional Feature:
- Macro: AES_KEY_STORE_EN.
- When defined:
  - Adds an internal 11x128 register file written with each round key as it becomes valid (index = rk_round).
  - Adds ports rd_addr input 4 and rd_key output 128. rd_key is a combinational read of entry rd_addr.
  - rd_addr>10 returns 0.
  - Store is cleared to 0 on rst.
  - Store contents are retained in IDLE, so a decrypt pass can read keys in reverse order without re-expanding.
- When undefined: no store and no rd_* ports; behaviour is otherwise identical.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start pulse, rk_ready=1 held.
  - Round 0 key equals key_in, 1 cycle after start.
  - Round 1 = a0fafe1788542cb123a339392a6c7605.
  - Round 2 = f2c295f27a96b9435935807a7359f67f.
  - Round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - done pulses 1 cycle after round-10 accept; 12 cycles total from start to done.
- Backpressure: same key, rk_ready toggled randomly.
  - rk_out/rk_round stable whenever rk_valid && !rk_ready.
  - Identical key sequence to the first test.
  - done exactly once.
- start asserted repeatedly during RUN with a different key_in → ignored; the sequence still matches the original key.
- rst asserted at rk_round=5 → next cycle all outputs 0 and IDLE, no done. A new start then yields the correct round 0 again.
- Key 000...0 → round 1 = 62636363626363636263636362636363; round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- With AES_KEY_STORE_EN, after the FIPS run:
  - rd_addr=0 → key_in; rd_addr=10 → d014f9a8c9ee2589e13f0cc8b6630ca6; rd_addr=15 → 0.
  - After rst, every entry reads 0.
